// File: rtl/jtdd_prog_pack.sv
// -----------------------------------------------------------------------------
// jtdd_prog_pack
//
// Packs the byte stream from the ioctl ROM loader into 16-bit SDRAM program
// words, queues them in a small FIFO with a write/acknowledge handshake toward
// the SDRAM controller, and steers bytes that fall in the PROM area to a set
// of on-chip PROMs as one-hot write strobes.
//
// Parameters
//   AW         ioctl byte-address width
//   SDW        SDRAM word-address width
//   SD_OFFSET  SDRAM word offset added to every packed word address
//   PROM_START first byte address of the PROM area
//   PROM_AW    address width of each PROM (2^PROM_AW bytes per PROM)
//   PROM_COUNT number of PROMs (1..8)
//   FIFO_AW    FIFO depth is 2^FIFO_AW entries
//
// Ports
//   clk          system clock (single clock domain)
//   rst_n        asynchronous active-low reset
//   downloading  high while the loader is active
//   ioctl_addr   loader byte address
//   ioctl_data   loader byte data
//   ioctl_wr     one-cycle byte strobe
//   ioctl_wait   asks the loader to hold off (FIFO nearly full)
//   prog_addr    SDRAM word address of the FIFO head
//   prog_data    SDRAM write data of the FIFO head
//   prog_mask    active-low byte mask of the FIFO head, bit0 = even byte
//   prog_we      write request, high while the FIFO is non-empty
//   prog_rdy     SDRAM acknowledge
//   prom_we      one-hot PROM write strobe, one cycle per byte
//   prom_addr    PROM byte address
//   prom_data    PROM byte data
//   dwnld_done   one-cycle pulse once the download has fully drained
//   overflow     sticky flag: an entry was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module jtdd_prog_pack #(
    parameter int             AW         = 22,
    parameter int             SDW        = 22,
    parameter logic [SDW-1:0] SD_OFFSET  = '0,
    parameter logic [AW-1:0]  PROM_START = 22'h124000,
    parameter int             PROM_AW    = 8,
    parameter int             PROM_COUNT = 4,
    parameter int             FIFO_AW    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  downloading,
    input  logic [AW-1:0]         ioctl_addr,
    input  logic [7:0]            ioctl_data,
    input  logic                  ioctl_wr,
    output logic                  ioctl_wait,
    output logic [SDW-1:0]        prog_addr,
    output logic [15:0]           prog_data,
    output logic [1:0]            prog_mask,
    output logic                  prog_we,
    input  logic                  prog_rdy,
    output logic [PROM_COUNT-1:0] prom_we,
    output logic [PROM_AW-1:0]    prom_addr,
    output logic [7:0]            prom_data,
    output logic                  dwnld_done,
    output logic                  overflow
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int PW    = FIFO_AW + 1;
    localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);
    localparam logic [PW:0] WAIT_W  = (PW+1)'(DEPTH - 2);

    typedef struct packed {
        logic [SDW-1:0] addr;
        logic [15:0]    data;
        logic [1:0]     mask;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic entry_t mk_entry(input logic [AW-2:0] wa,
                                        input logic [15:0]   d,
                                        input logic [1:0]    m);
        entry_t e;
        e.addr = SD_OFFSET + SDW'(wa);
        e.data = d;
        e.mask = m;
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t          state;
    logic            dl_q;
    logic [PW-1:0]   wp;
    logic [PW-1:0]   rp;
    entry_t          mem [DEPTH];
    logic            pend_vld;
    logic [AW-2:0]   pend_waddr;
    logic [7:0]      pend_data;

    // ------------------------------------------------------------------
    // FIFO status
    // ------------------------------------------------------------------
    logic [PW-1:0] count;
    logic          fifo_empty;
    logic          pop;
    logic [PW:0]   space;
    entry_t        head;
    logic [PW-1:0] wp_p1;

    // Pointers are one bit wider than the slot index, so wp - rp is the
    // occupancy 0..DEPTH without ambiguity between empty and full.
    assign count      = wp - rp;
    assign fifo_empty = (count == '0);
    assign wp_p1      = wp + PW'(1);
    assign head       = mem[rp[FIFO_AW-1:0]];

    // Handshake: an entry is offered on prog_addr/prog_data/prog_mask while
    // prog_we is high and is held stable until a cycle where prog_rdy is
    // sampled high together with prog_we; that cycle consumes the entry.
    // prog_rdy while prog_we is low has no effect.
    assign pop       = !fifo_empty && prog_rdy;
    assign prog_we   = !fifo_empty;
    assign prog_addr = fifo_empty ? '0     : head.addr;
    assign prog_data = fifo_empty ? '0     : head.data;
    assign prog_mask = fifo_empty ? 2'b11  : head.mask;

    // A slot freed by this cycle's pop may be reused by this cycle's push.
    assign space = DEPTH_W - {1'b0, count} + {{PW{1'b0}}, pop};

    // Two free slots are kept so one more byte (worst case two pushes) fits.
    assign ioctl_wait = ({1'b0, count} >= WAIT_W);

    // ------------------------------------------------------------------
    // Input decode
    // ------------------------------------------------------------------
    logic                  rise;
    logic                  fall;
    logic                  wr_act;
    logic                  in_sd;
    logic [AW-2:0]         waddr;
    logic [AW-1:0]         prom_off;
    logic [AW-1:0]         prom_idx;
    logic                  prom_hit;
    logic [PROM_COUNT-1:0] prom_onehot;

    assign rise   = downloading && !dl_q;
    assign fall   = !downloading && dl_q;
    // The falling-edge cycle still accepts a byte so it is packed before
    // the end-of-download flush.
    assign wr_act = ioctl_wr && (downloading || dl_q);
    assign in_sd  = (ioctl_addr < PROM_START);
    assign waddr  = ioctl_addr[AW-1:1];

    assign prom_off    = ioctl_addr - PROM_START;
    assign prom_idx    = prom_off >> PROM_AW;
    assign prom_hit    = wr_act && !in_sd && (prom_idx < AW'(PROM_COUNT));
    assign prom_onehot = PROM_COUNT'(1) << prom_idx;

    // ------------------------------------------------------------------
    // Packer: at most three candidate pushes in a fixed order
    //   pre  : the old pending byte flushed ahead of the new byte
    //   main : the odd byte (full word or lone odd byte)
    //   post : end-of-download flush of whatever is still pending
    // At most two of them can happen in one cycle.
    // ------------------------------------------------------------------
    logic          pre_vld;
    logic          main_vld;
    logic          post_vld;
    entry_t        pre_ent;
    entry_t        main_ent;
    entry_t        post_ent;
    logic          np_vld;
    logic [AW-2:0] np_waddr;
    logic [7:0]    np_data;
    entry_t        ent0;
    entry_t        ent1;
    logic [1:0]    n_push;
    logic          acc0;
    logic          acc1;
    logic          drop;

    always_comb begin
        pre_vld  = 1'b0;
        main_vld = 1'b0;
        post_vld = 1'b0;
        pre_ent  = mk_entry(pend_waddr, {8'h00, pend_data}, 2'b10);
        main_ent = mk_entry(waddr, {ioctl_data, 8'h00}, 2'b01);
        np_vld   = pend_vld;
        np_waddr = pend_waddr;
        np_data  = pend_data;

        if (wr_act) begin
            if (in_sd) begin
                if (!ioctl_addr[0]) begin
                    pre_vld  = pend_vld;
                    np_vld   = 1'b1;
                    np_waddr = waddr;
                    np_data  = ioctl_data;
                end else if (pend_vld && (pend_waddr == waddr)) begin
                    main_vld = 1'b1;
                    main_ent = mk_entry(waddr, {ioctl_data, pend_data}, 2'b00);
                    np_vld   = 1'b0;
                end else begin
                    pre_vld  = pend_vld;
                    main_vld = 1'b1;
                    np_vld   = 1'b0;
                end
            end else begin
                // Any PROM-area byte closes the current SDRAM word.
                pre_vld = pend_vld;
                np_vld  = 1'b0;
            end
        end

        post_ent = mk_entry(np_waddr, {8'h00, np_data}, 2'b10);
        if (fall && np_vld) begin
            post_vld = 1'b1;
            np_vld   = 1'b0;
        end

        // Compact the candidates into the two FIFO write ports.
        ent0   = pre_vld ? pre_ent : (main_vld ? main_ent : post_ent);
        ent1   = (pre_vld && main_vld) ? main_ent : post_ent;
        n_push = 2'(pre_vld) + 2'(main_vld) + 2'(post_vld);

        acc0 = (n_push != 2'd0) && (space != '0);
        acc1 = (n_push == 2'd2) && (space >= (PW+1)'(2));
        drop = ((n_push != 2'd0) && !acc0) || ((n_push == 2'd2) && !acc1);
    end

    // FIFO storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (acc0) mem[wp[FIFO_AW-1:0]]    <= ent0;
        if (acc1) mem[wp_p1[FIFO_AW-1:0]] <= ent1;
    end

    // ------------------------------------------------------------------
    // Pointers, pending byte, overflow, PROM strobes
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_q       <= 1'b0;
            wp         <= '0;
            rp         <= '0;
            pend_vld   <= 1'b0;
            pend_waddr <= '0;
            pend_data  <= '0;
            overflow   <= 1'b0;
            prom_we    <= '0;
            prom_addr  <= '0;
            prom_data  <= '0;
        end else begin
            dl_q       <= downloading;
            wp         <= wp + PW'(acc0) + PW'(acc1);
            rp         <= rp + PW'(pop);
            pend_vld   <= np_vld;
            pend_waddr <= np_waddr;
            pend_data  <= np_data;

            // A new download clears the flag; a drop in the same cycle wins.
            if (rise) overflow <= 1'b0;
            if (drop) overflow <= 1'b1;

            prom_we <= '0;
            if (prom_hit) begin
                prom_we   <= prom_onehot;
                prom_addr <= prom_off[PROM_AW-1:0];
                prom_data <= ioctl_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Download sequencing
    // DRAIN checks the registered occupancy, so dwnld_done appears at least
    // one cycle after the last entry was consumed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            dwnld_done <= 1'b0;
        end else begin
            dwnld_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rise) state <= S_LOAD;
                end
                S_LOAD: begin
                    if (fall) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (rise) begin
                        state <= S_LOAD;
                    end else if (fifo_empty) begin
                        state      <= S_DONE;
                        dwnld_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= rise ? S_LOAD : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtdd_prog_pack.sv
// -----------------------------------------------------------------------------
// tb_jtdd_prog_pack
//
// Bench for jtdd_prog_pack. A reference model watches the driven inputs at
// every rising clock edge and queues the SDRAM words and PROM strobes the
// block must produce; a monitor on the falling edge consumes those queues as
// the block presents writes and strobes.
// -----------------------------------------------------------------------------
module tb_jtdd_prog_pack;

    localparam int          AW         = 22;
    localparam int          SDW        = 22;
    localparam int          PROM_AW    = 8;
    localparam int          PROM_COUNT = 4;
    localparam int          FIFO_AW    = 2;
    localparam int          DEPTH      = 4;
    localparam logic [21:0] PROM_START = 22'h124000;
    localparam logic [21:0] SD_OFFSET  = 22'h0;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        rst_n;
    logic        downloading;
    logic [21:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic        ioctl_wait;
    logic [21:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        prog_rdy;
    logic [3:0]  prom_we;
    logic [7:0]  prom_addr;
    logic [7:0]  prom_data;
    logic        dwnld_done;
    logic        overflow;

    jtdd_prog_pack #(
        .AW(AW), .SDW(SDW), .SD_OFFSET(SD_OFFSET), .PROM_START(PROM_START),
        .PROM_AW(PROM_AW), .PROM_COUNT(PROM_COUNT), .FIFO_AW(FIFO_AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .ioctl_wait(ioctl_wait), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_mask(prog_mask), .prog_we(prog_we), .prog_rdy(prog_rdy),
        .prom_we(prom_we), .prom_addr(prom_addr), .prom_data(prom_data),
        .dwnld_done(dwnld_done), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [39:0] exp_q[$];     // {addr, data, mask}
    logic [19:0] prom_q[$];    // {we, addr, data}

    logic        m_pv = 1'b0;
    logic [20:0] m_pa = '0;
    logic [7:0]  m_pd = '0;
    logic        m_dl_prev = 1'b0;
    logic        m_ovf = 1'b0;
    logic        done_exp = 1'b0;
    logic        done_prev = 1'b0;
    logic        rdy_rand = 1'b0;
    int          cyc = 0;
    int          last_pop_cyc = -100;
    int          done_cnt = 0;
    int          prom_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [39:0] mk(input logic [20:0] wa, input logic [15:0] d,
                                       input logic [1:0] m);
        return {SD_OFFSET + 22'(wa), d, m};
    endfunction

    task automatic m_push(input logic [39:0] e);
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else m_ovf = 1'b1;
    endtask

    // ---------------- reference model ----------------
    initial begin : model
        logic        rise;
        logic        fall;
        logic [21:0] off;
        logic [21:0] idx;
        logic [20:0] wa;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                exp_q.delete();
                prom_q.delete();
                m_pv      = 1'b0;
                m_dl_prev = 1'b0;
                m_ovf     = 1'b0;
                done_exp  = 1'b0;
            end else begin
                rise = downloading && !m_dl_prev;
                fall = !downloading && m_dl_prev;
                if (rise) begin
                    m_ovf    = 1'b0;
                    done_exp = 1'b0;
                end
                if (ioctl_wr && (downloading || m_dl_prev)) begin
                    wa = ioctl_addr[21:1];
                    if (ioctl_addr < PROM_START) begin
                        if (!ioctl_addr[0]) begin
                            if (m_pv) m_push(mk(m_pa, {8'h00, m_pd}, 2'b10));
                            m_pv = 1'b1;
                            m_pa = wa;
                            m_pd = ioctl_data;
                        end else if (m_pv && m_pa == wa) begin
                            m_push(mk(wa, {ioctl_data, m_pd}, 2'b00));
                            m_pv = 1'b0;
                        end else begin
                            if (m_pv) m_push(mk(m_pa, {8'h00, m_pd}, 2'b10));
                            m_pv = 1'b0;
                            m_push(mk(wa, {ioctl_data, 8'h00}, 2'b01));
                        end
                    end else begin
                        if (m_pv) m_push(mk(m_pa, {8'h00, m_pd}, 2'b10));
                        m_pv = 1'b0;
                        off = ioctl_addr - PROM_START;
                        idx = off >> PROM_AW;
                        if (idx < 22'(PROM_COUNT))
                            prom_q.push_back({4'(1) << idx, off[7:0], ioctl_data});
                    end
                end
                if (fall) begin
                    if (m_pv) m_push(mk(m_pa, {8'h00, m_pd}, 2'b10));
                    m_pv     = 1'b0;
                    done_exp = 1'b1;
                end
                m_dl_prev = downloading;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [39:0] e;
        logic [19:0] p;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                chk("prog_we", 64'(prog_we), 64'(exp_q.size() != 0));
                chk("ioctl_wait", 64'(ioctl_wait), 64'(exp_q.size() >= DEPTH - 2));
                chk("overflow", 64'(overflow), 64'(m_ovf));
                if (prog_we && prog_rdy) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL sdram_write: unexpected write addr %0h data %0h mask %0b",
                                 prog_addr, prog_data, prog_mask);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sdram_write", 64'({prog_addr, prog_data, prog_mask}), 64'(e));
                    end
                    last_pop_cyc = cyc;
                end
                if (prom_we != 4'd0 || prom_q.size() != 0) begin
                    if (prom_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL prom_write: unexpected strobe %b addr %0h", prom_we, prom_addr);
                    end else begin
                        p = prom_q.pop_front();
                        chk("prom_write", 64'({prom_we, prom_addr, prom_data}), 64'(p));
                    end
                    if (prom_we != 4'd0) prom_cnt++;
                end
                if (dwnld_done) begin
                    chk("done_expected", 64'(done_exp), 64'(1));
                    chk("done_drained", 64'(exp_q.size()), 64'(0));
                    chk("done_after_pop", 64'(cyc >= last_pop_cyc + 2), 64'(1));
                    chk("done_width", 64'(done_prev), 64'(0));
                    done_exp = 1'b0;
                    done_cnt++;
                end
                done_prev = dwnld_done;
            end else begin
                done_prev = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    initial begin : rdy_gen
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) prog_rdy = 1'($urandom_range(0, 1));
        end
    end

    task automatic write_byte(input logic [21:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        @(posedge clk);
        #1;
        ioctl_wr = 1'b0;
    endtask

    task automatic write_and_end(input logic [21:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        ioctl_addr  = a;
        ioctl_data  = d;
        ioctl_wr    = 1'b1;
        downloading = 1'b0;
        @(posedge clk);
        #1;
        ioctl_wr = 1'b0;
    endtask

    task automatic start_dl();
        @(posedge clk);
        #1;
        downloading = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic end_dl();
        @(posedge clk);
        #1;
        downloading = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int  s;
        logic got;
        s   = done_cnt;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (done_cnt != s) begin
                got = 1'b1;
                break;
            end
        end
        #1;
        chk(name, 64'(got), 64'(1));
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int          ps;
        int          k;
        logic [21:0] a;

        rst_n       = 1'b0;
        downloading = 1'b0;
        ioctl_addr  = '0;
        ioctl_data  = '0;
        ioctl_wr    = 1'b0;
        prog_rdy    = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // reset values
        chk("rst_prog_we", 64'(prog_we), 64'(0));
        chk("rst_prog_mask", 64'(prog_mask), 64'(2'b11));
        chk("rst_prog_addr", 64'(prog_addr), 64'(0));
        chk("rst_prog_data", 64'(prog_data), 64'(0));
        chk("rst_ioctl_wait", 64'(ioctl_wait), 64'(0));
        chk("rst_prom_we", 64'(prom_we), 64'(0));
        chk("rst_prom_addr", 64'(prom_addr), 64'(0));
        chk("rst_prom_data", 64'(prom_data), 64'(0));
        chk("rst_done", 64'(dwnld_done), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // word packing
        start_dl();
        write_byte(22'h000, 8'h12);
        write_byte(22'h001, 8'h34);
        end_dl();
        wait_done("done_pack");

        // lone bytes
        start_dl();
        write_byte(22'h004, 8'hA4);
        write_byte(22'h008, 8'hA8);
        write_byte(22'h00B, 8'hAB);
        end_dl();
        wait_done("done_lone");

        // PROM steering, last byte beyond the final PROM
        start_dl();
        ps = prom_cnt;
        write_byte(22'h124000, 8'h51);
        write_byte(22'h124105, 8'h52);
        write_byte(22'h1243FF, 8'h53);
        write_byte(22'h124400, 8'h54);
        end_dl();
        wait_done("done_prom");
        chk("prom_pulses", 64'(prom_cnt - ps), 64'(3));

        // end flush with delayed acknowledge
        start_dl();
        prog_rdy = 1'b0;
        write_byte(22'h010, 8'hC3);
        end_dl();
        repeat (3) @(posedge clk);
        #1;
        prog_rdy = 1'b1;
        wait_done("done_flush");

        // byte written in the same cycle as the end of download
        start_dl();
        write_byte(22'h031, 8'h11);
        write_and_end(22'h032, 8'h22);
        wait_done("done_wr_end");

        // backpressure and overflow, ioctl_wait ignored
        start_dl();
        prog_rdy = 1'b0;
        for (int i = 0; i < 16; i++) write_byte(22'h080 + 22'(i), 8'($urandom_range(0, 255)));
        chk("bp_overflow", 64'(overflow), 64'(1));
        chk("bp_wait", 64'(ioctl_wait), 64'(1));
        prog_rdy = 1'b1;
        end_dl();
        wait_done("done_bp");

        // randomized traffic
        start_dl();
        rdy_rand = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) != 0) begin
                k = 0;
                while (ioctl_wait && k < 100) begin
                    @(posedge clk);
                    #1;
                    k++;
                end
                if (ioctl_wait) chk("wait_release", 64'(ioctl_wait), 64'(0));
            end
            if ($urandom_range(0, 9) < 7) a = 22'($urandom_range(0, 63));
            else a = PROM_START + 22'($urandom_range(0, 1279));
            write_byte(a, 8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        end_dl();
        wait_done("done_rand");
        rdy_rand = 1'b0;
        @(posedge clk);
        #1;
        prog_rdy = 1'b1;

        // reset with entries queued
        start_dl();
        prog_rdy = 1'b0;
        write_byte(22'h041, 8'h41);
        write_byte(22'h043, 8'h43);
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        downloading = 1'b0;
        #1;
        chk("midrst_prog_we", 64'(prog_we), 64'(0));
        chk("midrst_prog_mask", 64'(prog_mask), 64'(2'b11));
        chk("midrst_wait", 64'(ioctl_wait), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        prog_rdy = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        chk("end_sdram_queue", 64'(exp_q.size()), 64'(0));
        chk("end_prom_queue", 64'(prom_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
